// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared types for the multicycle ARM main FSM (TRAP state under ARM_MC_TRAP_EN)
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
`ifdef ARM_MC_TRAP_EN
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
`else
        S_BRANCH   = 4'd9
`endif
    } state_e;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/arm_mc_out_dec.sv
// rtl/arm_mc_out_dec.sv - Moore output decode: current state to control word
module arm_mc_out_dec
    import arm_mc_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/arm_mc_main_fsm.sv
// rtl/arm_mc_main_fsm.sv - multicycle ARM main control FSM; ARM_MC_TRAP_EN adds Trap output and TRAP state
module arm_mc_main_fsm
    import arm_mc_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic       Funct5,
    input  logic       Funct0,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
`ifdef ARM_MC_TRAP_EN
    output logic       InstrDone,
    output logic       Trap
`else
    output logic       InstrDone
`endif
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction fields matter only in DECODE and MEMADR; elsewhere they are ignored.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct5 ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
`ifdef ARM_MC_TRAP_EN
                    default: state_d = S_TRAP;
`else
                    default: state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = Funct0 ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
`ifdef ARM_MC_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    arm_mc_out_dec u_out_dec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign IRWrite   = ctrl.ir_write;
    assign NextPC    = ctrl.next_pc;
    assign RegW      = ctrl.reg_w;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ALUOp     = ctrl.alu_op;
    assign InstrDone = ctrl.instr_done;
`ifdef ARM_MC_TRAP_EN
    assign Trap      = (state_q == S_TRAP);
`endif

endmodule

// File: doc/arm_mc_main_fsm.md
# arm_mc_main_fsm

Main control state machine for the multicycle ARM processor. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath multiplexer selects and the unconditional write requests (RegW, MemW, Branch, NextPC), which the downstream conditional logic gates with the condition-check result. It sits directly upstream of the conditional logic / PC-source block and is fed from the instruction register.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- Op  in  2  instruction bits [27:26] from instruction register: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct5  in  1  instruction bit 25 (I: immediate operand).
- Funct0  in  1  instruction bit 20 (S for data-processing, L for memory).
- IRWrite  out  1  load instruction register.
- NextPC  out  1  unconditional PC write (PC+4).
- RegW  out  1  register-write request, pre-condition.
- MemW  out  1  memory-write request, pre-condition.
- Branch  out  1  branch request, pre-condition.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result.
- ALUSrcA  out  2  00 = Rn, 01 = PC.
- ALUSrcB  out  2  00 = Rm/shifted, 01 = immediate, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = ADD.
- InstrDone  out  1  high in the final state of every instruction.
- Trap  out  1  present only with ARM_MC_TRAP_EN.

## Operation
- Moore machine. All outputs decode from the current state only. Outputs not listed for a state are 0.
- States and outputs:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1, InstrDone=1.
  - MEMWRITE: AdrSrc=1, MemW=1, InstrDone=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, InstrDone=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1, InstrDone=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=00 with Funct5=0 → EXECUTER.
    - Op=00 with Funct5=1 → EXECUTEI.
    - Op=10 → BRANCH.
    - Op=11 → see Configuration.
  - MEMADR: Funct0=1 → MEMREAD; Funct0=0 → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
- Op, Funct5 and Funct0 are sampled only in DECODE and MEMADR. At other times they may be X without effect.
- An unreachable or illegal state encoding returns to FETCH on the next edge.

## Timing
- Reset: state=FETCH asynchronously; outputs immediately show the FETCH decode.
  - Datapath registers are held in reset concurrently, so IRWrite=1 and NextPC=1 during reset are harmless.
- First edge after reset deasserts: FETCH completes and state becomes DECODE.
- Instruction latencies, FETCH to the cycle after InstrDone:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
- reset mid-instruction: abandons the instruction; no RegW or MemW pulse is issued after reset asserts.
- Inputs must be stable before the edge that leaves DECODE and the edge that leaves MEMADR.

## Configuration
- ARM_MC_TRAP_EN defined:
  - Adds the Trap output and a TRAP state.
  - DECODE with Op=11 → TRAP.
  - TRAP holds until reset. It drives Trap=1 and all other outputs 0.
- ARM_MC_TRAP_EN undefined:
  - No Trap port and no TRAP state.
  - DECODE with Op=11 → FETCH, so the instruction executes as a NOP.
  - InstrDone is not asserted for an Op=11 instruction.

## Structure
- Package arm_mc_pkg holds:
  - the state enum;
  - a packed control-word struct covering all outputs except Trap;
  - named constants for the ALUSrcA, ALUSrcB and ResultSrc encodings.
- Sub-module arm_mc_out_dec is combinational: state in, control word out.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset while in MEMWRITE → state=FETCH immediately; MemW=0; IRWrite=1 and NextPC=1.
- Op=01, Funct0=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegW=1 and ResultSrc=01 only in the 5th cycle.
  - InstrDone pulses once.
- Op=01, Funct0=0 → MemW=1 and AdrSrc=1 in the 4th cycle only; RegW never set.
- Op=00 with Funct5=0, then with Funct5=1 → ALUSrcB=00 and then 01 in the 3rd cycle; ALUOp=1; RegW=1 in the 4th cycle.
- Op=10 → Branch=1, ALUSrcB=01 and InstrDone=1 in the 3rd cycle; FETCH on the 4th cycle.
- Op=11:
  - With the macro: Trap=1 is held for 10 cycles, then reset recovers to FETCH.
  - Without the macro: FETCH on the 3rd cycle and no write requests.
